// File: rtl/lsu_initiator_pkg.sv
// Shared types and constants for the load/store initiator.
// Op and state encodings plus small decode helpers.
package lsu_initiator_pkg;

    localparam int ADDR_W_DEF  = 12;
    localparam int TIMEOUT_DEF = 16;
    localparam int MEM_BYTES   = 4 * (2 ** ADDR_W_DEF);

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_R,
        S_DONE
    } state_e;

    function automatic logic is_store(op_e o);
        return (o == OP_SW) || (o == OP_SH) || (o == OP_SB);
    endfunction

    function automatic logic misaligned(op_e o, logic [1:0] off);
        logic bad;
        bad = 1'b0;
        unique case (o)
            OP_LW, OP_SW:         bad = (off != 2'b00);
            OP_LH, OP_LHU, OP_SH: bad = off[0];
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store enables/replication and load extraction.
// Purely combinational.
module lsu_lane_align
    import lsu_initiator_pkg::*;
(
    input  op_e         op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] st_data_o,
    output logic [31:0] ld_data_o
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    always_comb begin
        half     = off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        byte_sel = ld_word_i[7:0];
        unique case (off_i)
            2'd0: byte_sel = ld_word_i[7:0];
            2'd1: byte_sel = ld_word_i[15:8];
            2'd2: byte_sel = ld_word_i[23:16];
            2'd3: byte_sel = ld_word_i[31:24];
        endcase
    end

    always_comb begin
        be_o      = 4'b0000;
        st_data_o = st_data_i;
        ld_data_o = ld_word_i;
        unique case (op_i)
            OP_LW:  ld_data_o = ld_word_i;
            OP_LH:  ld_data_o = {{16{half[15]}}, half};
            OP_LHU: ld_data_o = {16'h0000, half};
            OP_LB:  ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: ld_data_o = {24'h000000, byte_sel};
            OP_SW: begin
                be_o      = 4'b1111;
                st_data_o = st_data_i;
            end
            OP_SH: begin
                be_o      = off_i[1] ? 4'b1100 : 4'b0011;
                st_data_o = {2{st_data_i[15:0]}};
            end
            OP_SB: begin
                be_o      = 4'b0001 << off_i;
                st_data_o = {4{st_data_i[7:0]}};
            end
        endcase
    end

endmodule

// File: rtl/lsu_initiator.sv
// Load/store initiator: checks an access, runs the req/gnt/rvalid
// handshake, and returns extended load data with a done pulse.
module lsu_initiator
    import lsu_initiator_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err_align,
    output logic              err_range,
    output logic              err_bus,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wd_q, wd_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ea_q, ea_d;
    logic              er_q, er_d;
    logic              eb_q, eb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    op_e         op_in;
    op_e         al_op;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wd;
    logic [31:0] al_ld;
    logic        bad_align;
    logic        bad_range;
    logic        st_in;

    assign op_in = op_e'(op);

    // In IDLE the aligner sees the incoming op; afterwards the latched one.
    assign al_op  = (state_q == S_IDLE) ? op_in : op_q;
    assign al_off = (state_q == S_IDLE) ? addr[1:0] : off_q;

    lsu_lane_align u_align (
        .op_i      (al_op),
        .off_i     (al_off),
        .st_data_i (wdata),
        .ld_word_i (mem_rdata),
        .be_o      (al_be),
        .st_data_o (al_wd),
        .ld_data_o (al_ld)
    );

    assign bad_align = misaligned(op_in, addr[1:0]);
    assign bad_range = |(addr >> (ADDR_W + 2));
    assign st_in     = is_store(op_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_LW;
            off_q   <= 2'b00;
            maddr_q <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wd_q    <= '0;
            rdata_q <= '0;
            ea_q    <= 1'b0;
            er_q    <= 1'b0;
            eb_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            off_q   <= off_d;
            maddr_q <= maddr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            ea_q    <= ea_d;
            er_q    <= er_d;
            eb_q    <= eb_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        off_d   = off_q;
        maddr_d = maddr_q;
        we_d    = we_q;
        be_d    = be_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        ea_d    = ea_q;
        er_d    = er_q;
        eb_d    = eb_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op_in;
                    off_d   = addr[1:0];
                    maddr_d = addr[ADDR_W+1:2];
                    we_d    = st_in;
                    be_d    = st_in ? al_be : 4'b0000;
                    wd_d    = st_in ? al_wd : 32'h0;
                    rdata_d = 32'h0;
                    ea_d    = bad_align;
                    er_d    = bad_range;
                    eb_d    = 1'b0;
                    state_d = (bad_align || bad_range) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = we_q ? S_DONE : S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                if (mem_rvalid) begin
                    rdata_d = al_ld;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = 32'h0;
                    eb_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wd_q;
    assign rdata     = rdata_q;
    assign err_align = ea_q;
    assign err_range = er_q;
    assign err_bus   = eb_q;

endmodule

// File: tb/tb_lsu_initiator.sv
// Scoreboard bench for lsu_initiator: directed ops, queued expectations,
// and a done-pulse monitor.
module tb_lsu_initiator;

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3;
    localparam logic [2:0] LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk, reset, start;
    logic [2:0]  op;
    logic [31:0] addr, wdata;
    logic        busy, done;
    logic [31:0] rdata;
    logic        err_align, err_range, err_bus;
    logic        mem_req, mem_we;
    logic [11:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rd;
        logic        ea;
        logic        er;
        logic        eb;
    } exp_t;

    exp_t sb[$];

    lsu_initiator dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .err_align  (err_align),
        .err_range  (err_range),
        .err_bus    (err_bus),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sb.pop_front();
                chk("rdata", rdata, e.rd);
                chk("err_align", {31'b0, err_align}, {31'b0, e.ea});
                chk("err_range", {31'b0, err_range}, {31'b0, e.er});
                chk("err_bus", {31'b0, err_bus}, {31'b0, e.eb});
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(
        input string       nm,
        input logic [2:0]  o,
        input logic [31:0] a,
        input logic [31:0] wd,
        input int          gnt_wait,
        input int          rv_after,
        input logic [31:0] rword,
        input logic [31:0] x_rd,
        input logic        x_ea,
        input logic        x_er,
        input logic        x_eb,
        input int          x_lat,
        input int          x_reqs,
        input logic [11:0] x_addr,
        input logic        x_we,
        input logic [3:0]  x_be,
        input logic [31:0] x_wd,
        input bit          spur
    );
        int c, reqs, gnt_c, lat;
        exp_t e;
        e.rd = x_rd;
        e.ea = x_ea;
        e.er = x_er;
        e.eb = x_eb;
        sb.push_back(e);
        op = o;
        addr = a;
        wdata = wd;
        mem_rdata = rword;
        start = 1'b1;
        next_cyc();
        start = 1'b0;
        c = 1;
        reqs = 0;
        gnt_c = 0;
        lat = -1;
        while (c <= 60) begin
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (spur) begin
                start = 1'b1;
                op = LB;
                addr = 32'h0000_0001;
            end
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            if (mem_req === 1'b1) begin
                reqs++;
                chk({nm, "_maddr"}, {20'b0, mem_addr}, {20'b0, x_addr});
                chk({nm, "_we"}, {31'b0, mem_we}, {31'b0, x_we});
                chk({nm, "_be"}, {28'b0, mem_be}, {28'b0, x_be});
                chk({nm, "_wd"}, mem_wdata, x_wd);
                if (reqs > gnt_wait) begin
                    mem_gnt = 1'b1;
                    gnt_c = c;
                end
            end else if (gnt_c != 0 && rv_after != 0
                         && c == gnt_c + rv_after) begin
                mem_rvalid = 1'b1;
            end
            next_cyc();
            c++;
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        chk({nm, "_latency"}, lat, x_lat);
        chk({nm, "_reqs"}, reqs, x_reqs);
        next_cyc();
        start = 1'b0;
        if (spur)
            chk({nm, "_idle_after"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op = LW;
        addr = 0;
        wdata = 0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 0;
        repeat (3) next_cyc();
        reset = 1'b0;
        next_cyc();

        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem", {mem_we, mem_be, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_errs", {29'b0, err_align, err_range, err_bus}, 32'd0);

        do_op("sb", SB, 32'h13, 32'h1234_56AB, 0, 0, 0,
              32'h0, 0, 0, 0, 2, 1, 12'h004, 1, 4'b1000, 32'hABAB_ABAB, 0);
        do_op("sw", SW, 32'hC, 32'h1122_3344, 0, 0, 0,
              32'h0, 0, 0, 0, 2, 1, 12'h003, 1, 4'b1111, 32'h1122_3344, 0);
        do_op("lh", LH, 32'h22, 0, 0, 2, 32'h8001_7FFF,
              32'hFFFF_8001, 0, 0, 0, 4, 1, 12'h008, 0, 4'b0000, 32'h0, 0);
        do_op("lhu", LHU, 32'h22, 0, 0, 2, 32'h8001_7FFF,
              32'h0000_8001, 0, 0, 0, 4, 1, 12'h008, 0, 4'b0000, 32'h0, 0);
        do_op("lb", LB, 32'h20, 0, 0, 2, 32'h8001_7FFF,
              32'hFFFF_FFFF, 0, 0, 0, 4, 1, 12'h008, 0, 4'b0000, 32'h0, 0);
        do_op("lbu", LBU, 32'h21, 0, 0, 1, 32'h8001_7FFF,
              32'h0000_007F, 0, 0, 0, 3, 1, 12'h008, 0, 4'b0000, 32'h0, 0);
        do_op("lw", LW, 32'h24, 0, 0, 1, 32'h8001_7FFF,
              32'h8001_7FFF, 0, 0, 0, 3, 1, 12'h009, 0, 4'b0000, 32'h0, 0);
        do_op("lw_mis", LW, 32'h6, 0, 0, 0, 0,
              32'h0, 1, 0, 0, 1, 0, 12'h0, 0, 4'b0, 32'h0, 0);
        do_op("sw_rng", SW, 32'h4000, 32'h5555_5555, 0, 0, 0,
              32'h0, 0, 1, 0, 1, 0, 12'h0, 0, 4'b0, 32'h0, 0);
        do_op("lh_both", LH, 32'h4001, 0, 0, 0, 0,
              32'h0, 1, 1, 0, 1, 0, 12'h0, 0, 4'b0, 32'h0, 0);
        do_op("sh_stall", SH, 32'h3FFE, 32'hDEAD_BEEF, 5, 0, 0,
              32'h0, 0, 0, 0, 7, 6, 12'hFFF, 1, 4'b1100, 32'hBEEF_BEEF, 1);
        do_op("lw_tmo", LW, 32'h40, 0, 0, 0, 32'h1234_5678,
              32'h0, 0, 0, 1, 18, 1, 12'h010, 0, 4'b0000, 32'h0, 0);

        // Late read response while idle must not disturb anything.
        mem_rvalid = 1'b1;
        next_cyc();
        next_cyc();
        mem_rvalid = 1'b0;
        chk("late_busy", {31'b0, busy}, 32'd0);
        chk("late_done", {31'b0, done}, 32'd0);
        chk("late_rdata", rdata, 32'd0);
        chk("late_errbus", {31'b0, err_bus}, 32'd1);

        // Reset while waiting for read data.
        op = LW;
        addr = 32'h80;
        start = 1'b1;
        next_cyc();
        start = 1'b0;
        mem_gnt = 1'b1;
        next_cyc();
        mem_gnt = 1'b0;
        next_cyc();
        chk("pre_rst_wait", {31'b0, busy & ~mem_req}, 32'd1);
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mid_done", {31'b0, done}, 32'd0);
        next_cyc();
        chk("rst_mid_done2", {31'b0, done}, 32'd0);

        do_op("lw_after", LW, 32'h100, 0, 0, 1, 32'hCAFE_BABE,
              32'hCAFE_BABE, 0, 0, 0, 3, 1, 12'h040, 0, 4'b0000, 32'h0, 0);

        repeat (3) next_cyc();
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
